// File: rtl/id_regfile_if.sv
// id_regfile_if: bundle between the decode-stage register file and the
// surrounding pipeline. It carries the WB write-back bus, the EX and MEM
// forwarding/status buses, the two ID read ports and the stall output.
// The master side is the pipeline (WB/EX/MEM/ID), and the slave side is
// the register file.

interface id_regfile_if #(
    parameter int RF_AW = 5,
    parameter int RF_DW = 32
);
    // {rf_we, dest, wdata}
    logic                         ws_valid;
    logic [RF_DW+RF_AW:0]         ws_to_rf_bus;
    // {es_valid, es_rf_we, es_is_load, es_dest, es_result}
    logic [RF_DW+RF_AW+2:0]       es_to_ds_bus;
    // {ms_valid, ms_rf_we, ms_res_ok, ms_dest, ms_result}
    logic [RF_DW+RF_AW+2:0]       ms_to_ds_bus;

    logic                         ds_valid;
    logic [RF_AW-1:0]             raddr1;
    logic [RF_AW-1:0]             raddr2;
    logic                         use1;
    logic                         use2;
    logic [RF_DW-1:0]             rdata1;
    logic [RF_DW-1:0]             rdata2;
    logic                         ds_stall;

    modport master (
        output ws_valid, ws_to_rf_bus, es_to_ds_bus, ms_to_ds_bus,
        output ds_valid, raddr1, raddr2, use1, use2,
        input  rdata1, rdata2, ds_stall
    );

    modport slave (
        input  ws_valid, ws_to_rf_bus, es_to_ds_bus, ms_to_ds_bus,
        input  ds_valid, raddr1, raddr2, use1, use2,
        output rdata1, rdata2, ds_stall
    );
endinterface

// File: rtl/id_regfile.sv
// id_regfile: decode-stage register file for the LoongArch pipeline.
// This block holds 32 GPRs, and r0 always reads as zero. It has one write
// port fed by WB and two combinational read ports. Each read port resolves
// its value from the youngest producer first: EX, then MEM, then WB
// write-through, then the array.
// Optional feature macro: RF_BYPASS_EN. When this macro is defined, EX and
// MEM results are forwarded to the read ports, and ID stalls only on a
// load-use case. When the macro is not defined, ID stalls on any EX or MEM
// producer of a source it uses, until that value reaches WB.

module id_regfile #(
    parameter int RF_AW = 5,
    parameter int RF_DW = 32
) (
    input  logic clk,
    input  logic rst,
    id_regfile_if.slave rf
);

    localparam int NREG = 2 ** RF_AW;

    logic [RF_DW-1:0] rf_q [NREG];

    logic             wbWe;
    logic [RF_AW-1:0] wbDest;
    logic [RF_DW-1:0] wbData;
    logic             esValid;
    logic             esWe;
    logic             esIsLoad;
    logic [RF_AW-1:0] esDest;
    logic [RF_DW-1:0] esResult;
    logic             msValid;
    logic             msWe;
    logic             msResOk;
    logic [RF_AW-1:0] msDest;
    logic [RF_DW-1:0] msResult;
    logic             wrEn;
    logic             hazard1;
    logic             hazard2;

    assign {wbWe, wbDest, wbData} = rf.ws_to_rf_bus;
    assign {esValid, esWe, esIsLoad, esDest, esResult} = rf.es_to_ds_bus;
    assign {msValid, msWe, msResOk, msDest, msResult} = rf.ms_to_ds_bus;

    assign wrEn = rf.ws_valid & wbWe & (wbDest != '0);

`ifndef RF_BYPASS_EN
    // The forwarded values and the load status are only consumed by the
    // bypass network. They are collected here so that they have a reader
    // in the stall-only build.
    logic unused_ok;
    assign unused_ok = ^{esIsLoad, esResult, msResOk, msResult};
`endif

    function automatic logic esHit(input logic [RF_AW-1:0] a);
        return esValid & esWe & (esDest == a);
    endfunction

    function automatic logic msHit(input logic [RF_AW-1:0] a);
        return msValid & msWe & (msDest == a);
    endfunction

    function automatic logic wbHit(input logic [RF_AW-1:0] a);
        return rf.ws_valid & wbWe & (wbDest == a);
    endfunction

    // Operand resolution: the first matching source wins, from the youngest
    // producer down to the architectural array.
    function automatic logic [RF_DW-1:0] resolveRead(input logic [RF_AW-1:0] a);
        logic [RF_DW-1:0] v;
        if (a == '0)
            v = '0;
`ifdef RF_BYPASS_EN
        else if (esHit(a))
            v = esResult;
        else if (msHit(a))
            v = msResult;
`endif
        else if (wbHit(a))
            v = wbData;
        else
            v = rf_q[a];
        return v;
    endfunction

    // Operand availability check. r0 and unused sources never wait. With
    // bypassing, only a load still in EX, or a MEM load whose data has not
    // returned, holds ID. If an EX producer exists, it shadows MEM.
    function automatic logic hazard(input logic [RF_AW-1:0] a, input logic u);
        logic h;
        h = 1'b0;
        if (u && (a != '0)) begin
`ifdef RF_BYPASS_EN
            if (esHit(a))
                h = esIsLoad;
            else if (msHit(a))
                h = ~msResOk;
`else
            h = esHit(a) | msHit(a);
`endif
        end
        return h;
    endfunction

    // Register array. Reset clears every entry immediately. r0 is never
    // written, so it stays at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                rf_q[i] <= '0;
        end else if (wrEn) begin
            rf_q[wbDest] <= wbData;
        end
    end

    // Zero-latency read ports and stall generation for the ID stage.
    always_comb begin
        rf.rdata1   = resolveRead(rf.raddr1);
        rf.rdata2   = resolveRead(rf.raddr2);
        hazard1     = hazard(rf.raddr1, rf.use1);
        hazard2     = hazard(rf.raddr2, rf.use2);
        rf.ds_stall = rf.ds_valid & (hazard1 | hazard2);
    end

endmodule

// File: tb/tb_id_regfile.sv
// tb_id_regfile: directed testbench for id_regfile.
// It runs one task per scenario, and each task checks its own expected
// values. The tests that depend on bypassing follow the RF_BYPASS_EN build
// option.

module tb_id_regfile;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    id_regfile_if #(.RF_AW(5), .RF_DW(32)) rfIf ();

    id_regfile #(.RF_AW(5), .RF_DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .rf  (rfIf)
    );

    // Free-running clock; rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic driveWb(input logic v, input logic we, input logic [4:0] d,
                           input logic [31:0] data);
        rfIf.ws_valid     = v;
        rfIf.ws_to_rf_bus = {we, d, data};
    endtask

    task automatic driveEx(input logic v, input logic we, input logic ld,
                           input logic [4:0] d, input logic [31:0] res);
        rfIf.es_to_ds_bus = {v, we, ld, d, res};
    endtask

    task automatic driveMs(input logic v, input logic we, input logic ok,
                           input logic [4:0] d, input logic [31:0] res);
        rfIf.ms_to_ds_bus = {v, we, ok, d, res};
    endtask

    task automatic driveRead(input logic [4:0] a1, input logic u1,
                             input logic [4:0] a2, input logic u2);
        rfIf.raddr1 = a1;
        rfIf.use1   = u1;
        rfIf.raddr2 = a2;
        rfIf.use2   = u2;
    endtask

    task automatic idle();
        driveWb(1'b0, 1'b0, 5'd0, 32'h0);
        driveEx(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        driveMs(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        driveRead(5'd0, 1'b0, 5'd0, 1'b0);
        rfIf.ds_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        driveRead(5'd5, 1'b1, 5'd0, 1'b0);
        driveWb(1'b1, 1'b1, 5'd5, 32'h0000_1234);
        step();
        driveWb(1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        checks++;
        if (rfIf.rdata1 !== 32'h0000_1234) begin
            failures++;
            $display("[TB] FAIL reset_prewrite_r5 got=%h exp=%h", rfIf.rdata1, 32'h0000_1234);
        end
        // assert reset mid-cycle, away from any clock edge
        #1 rst = 1'b1;
        #1;
        checks++;
        if (rfIf.rdata1 !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_async_clear_r5 got=%h exp=%h", rfIf.rdata1, 32'h0);
        end
        checks++;
        if (rfIf.ds_stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_stall got=%b exp=%b", rfIf.ds_stall, 1'b0);
        end
        // a write attempted across an edge while reset is held must be dropped
        driveRead(5'd5, 1'b1, 5'd6, 1'b1);
        driveWb(1'b1, 1'b1, 5'd6, 32'h0000_BEEF);
        step();
        driveWb(1'b0, 1'b0, 5'd0, 32'h0);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (rfIf.rdata2 !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_write_suppressed_r6 got=%h exp=%h", rfIf.rdata2, 32'h0);
        end
        // the first edge after release performs a normal write
        driveWb(1'b1, 1'b1, 5'd6, 32'h0000_0077);
        step();
        driveWb(1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        checks++;
        if (rfIf.rdata2 !== 32'h0000_0077) begin
            failures++;
            $display("[TB] FAIL reset_release_write_r6 got=%h exp=%h", rfIf.rdata2, 32'h0000_0077);
        end
        checks++;
        if (rfIf.rdata1 !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_r5_stays_zero got=%h exp=%h", rfIf.rdata1, 32'h0);
        end
        idle();
    endtask

    task automatic test_r0();
        rfIf.ds_valid = 1'b1;
        driveRead(5'd0, 1'b1, 5'd0, 1'b1);
        driveWb(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF);
        #1;
        checks++;
        if (rfIf.rdata1 !== 32'h0) begin
            failures++;
            $display("[TB] FAIL r0_no_writethrough got=%h exp=%h", rfIf.rdata1, 32'h0);
        end
        step();
        driveWb(1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        checks++;
        if (rfIf.rdata2 !== 32'h0) begin
            failures++;
            $display("[TB] FAIL r0_after_write got=%h exp=%h", rfIf.rdata2, 32'h0);
        end
        driveEx(1'b1, 1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF);
        #1;
        checks++;
        if (rfIf.ds_stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL r0_ex_producer_stall got=%b exp=%b", rfIf.ds_stall, 1'b0);
        end
        checks++;
        if (rfIf.rdata1 !== 32'h0) begin
            failures++;
            $display("[TB] FAIL r0_ex_producer_value got=%h exp=%h", rfIf.rdata1, 32'h0);
        end
        idle();
    endtask

    task automatic test_write_through();
        driveRead(5'd0, 1'b0, 5'd7, 1'b1);
        driveWb(1'b1, 1'b1, 5'd7, 32'hA5A5_A5A5);
        #1;
        checks++;
        if (rfIf.rdata2 !== 32'hA5A5_A5A5) begin
            failures++;
            $display("[TB] FAIL wt_same_cycle got=%h exp=%h", rfIf.rdata2, 32'hA5A5_A5A5);
        end
        step();
        // the WB instruction carries no register write, so r7 is untouched
        driveWb(1'b1, 1'b0, 5'd7, 32'h5A5A_5A5A);
        #1;
        checks++;
        if (rfIf.rdata2 !== 32'hA5A5_A5A5) begin
            failures++;
            $display("[TB] FAIL wt_from_array got=%h exp=%h", rfIf.rdata2, 32'hA5A5_A5A5);
        end
        step();
        driveWb(1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        checks++;
        if (rfIf.rdata2 !== 32'hA5A5_A5A5) begin
            failures++;
            $display("[TB] FAIL wt_no_we_no_write got=%h exp=%h", rfIf.rdata2, 32'hA5A5_A5A5);
        end
        idle();
    endtask

    task automatic test_same_addr();
        driveWb(1'b1, 1'b1, 5'd11, 32'hCAFE_0011);
        step();
        driveWb(1'b0, 1'b0, 5'd0, 32'h0);
        driveRead(5'd11, 1'b1, 5'd11, 1'b1);
        #1;
        checks++;
        if (rfIf.rdata1 !== 32'hCAFE_0011) begin
            failures++;
            $display("[TB] FAIL same_addr_port1 got=%h exp=%h", rfIf.rdata1, 32'hCAFE_0011);
        end
        checks++;
        if (rfIf.rdata2 !== 32'hCAFE_0011) begin
            failures++;
            $display("[TB] FAIL same_addr_port2 got=%h exp=%h", rfIf.rdata2, 32'hCAFE_0011);
        end
        driveRead(5'd12, 1'b1, 5'd6, 1'b1);
        #1;
        checks++;
        if (rfIf.rdata1 !== 32'h0) begin
            failures++;
            $display("[TB] FAIL unwritten_r12 got=%h exp=%h", rfIf.rdata1, 32'h0);
        end
        checks++;
        if (rfIf.rdata2 !== 32'h0000_0077) begin
            failures++;
            $display("[TB] FAIL hold_r6 got=%h exp=%h", rfIf.rdata2, 32'h0000_0077);
        end
        idle();
    endtask

    task automatic test_stall_gating();
        // an unused port, an invalid ID, and a non-writing producer never stall
        rfIf.ds_valid = 1'b1;
        driveRead(5'd0, 1'b0, 5'd4, 1'b0);
        driveEx(1'b1, 1'b1, 1'b1, 5'd4, 32'h1);
        #1;
        checks++;
        if (rfIf.ds_stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL gate_unused_port got=%b exp=%b", rfIf.ds_stall, 1'b0);
        end
        driveRead(5'd0, 1'b0, 5'd4, 1'b1);
        rfIf.ds_valid = 1'b0;
        #1;
        checks++;
        if (rfIf.ds_stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL gate_ds_invalid got=%b exp=%b", rfIf.ds_stall, 1'b0);
        end
        rfIf.ds_valid = 1'b1;
        driveEx(1'b1, 1'b0, 1'b1, 5'd4, 32'h1);
        #1;
        checks++;
        if (rfIf.ds_stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL gate_ex_no_we got=%b exp=%b", rfIf.ds_stall, 1'b0);
        end
        driveEx(1'b0, 1'b1, 1'b1, 5'd4, 32'h1);
        #1;
        checks++;
        if (rfIf.ds_stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL gate_ex_invalid got=%b exp=%b", rfIf.ds_stall, 1'b0);
        end
        idle();
    endtask

`ifdef RF_BYPASS_EN
    task automatic test_priority();
        driveRead(5'd3, 1'b1, 5'd0, 1'b0);
        driveEx(1'b1, 1'b1, 1'b0, 5'd3, 32'h11);
        driveMs(1'b1, 1'b1, 1'b1, 5'd3, 32'h22);
        driveWb(1'b1, 1'b1, 5'd3, 32'h33);
        #1;
        checks++;
        if (rfIf.rdata1 !== 32'h11) begin
            failures++;
            $display("[TB] FAIL prio_ex got=%h exp=%h", rfIf.rdata1, 32'h11);
        end
        driveEx(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        checks++;
        if (rfIf.rdata1 !== 32'h22) begin
            failures++;
            $display("[TB] FAIL prio_mem got=%h exp=%h", rfIf.rdata1, 32'h22);
        end
        driveMs(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        checks++;
        if (rfIf.rdata1 !== 32'h33) begin
            failures++;
            $display("[TB] FAIL prio_wb got=%h exp=%h", rfIf.rdata1, 32'h33);
        end
        // an EX ALU producer shadows a pending MEM load to the same register
        rfIf.ds_valid = 1'b1;
        driveEx(1'b1, 1'b1, 1'b0, 5'd3, 32'h44);
        driveMs(1'b1, 1'b1, 1'b0, 5'd3, 32'h55);
        #1;
        checks++;
        if (rfIf.ds_stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL prio_ex_shadows_mem_stall got=%b exp=%b", rfIf.ds_stall, 1'b0);
        end
        idle();
    endtask

    task automatic test_load_use();
        rfIf.ds_valid = 1'b1;
        driveRead(5'd9, 1'b1, 5'd0, 1'b0);
        driveEx(1'b1, 1'b1, 1'b1, 5'd9, 32'h0);
        #1;
        checks++;
        if (rfIf.ds_stall !== 1'b1) begin
            failures++;
            $display("[TB] FAIL lu_ex_load got=%b exp=%b", rfIf.ds_stall, 1'b1);
        end
        step();
        driveEx(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        driveMs(1'b1, 1'b1, 1'b0, 5'd9, 32'h0);
        #1;
        checks++;
        if (rfIf.ds_stall !== 1'b1) begin
            failures++;
            $display("[TB] FAIL lu_mem_pending got=%b exp=%b", rfIf.ds_stall, 1'b1);
        end
        step();
        driveMs(1'b1, 1'b1, 1'b1, 5'd9, 32'h0000_9999);
        #1;
        checks++;
        if (rfIf.ds_stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL lu_mem_ready_stall got=%b exp=%b", rfIf.ds_stall, 1'b0);
        end
        checks++;
        if (rfIf.rdata1 !== 32'h0000_9999) begin
            failures++;
            $display("[TB] FAIL lu_mem_ready_value got=%h exp=%h", rfIf.rdata1, 32'h0000_9999);
        end
        driveMs(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        driveEx(1'b1, 1'b1, 1'b1, 5'd9, 32'h0);
        driveRead(5'd9, 1'b0, 5'd0, 1'b0);
        #1;
        checks++;
        if (rfIf.ds_stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL lu_unused_source got=%b exp=%b", rfIf.ds_stall, 1'b0);
        end
        idle();
    endtask
`else
    task automatic test_no_bypass();
        rfIf.ds_valid = 1'b1;
        driveRead(5'd0, 1'b0, 5'd4, 1'b1);
        driveEx(1'b1, 1'b1, 1'b0, 5'd4, 32'h0000_4444);
        #1;
        checks++;
        if (rfIf.ds_stall !== 1'b1) begin
            failures++;
            $display("[TB] FAIL nb_ex_stall got=%b exp=%b", rfIf.ds_stall, 1'b1);
        end
        step();
        driveEx(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        driveMs(1'b1, 1'b1, 1'b1, 5'd4, 32'h0000_4444);
        #1;
        checks++;
        if (rfIf.ds_stall !== 1'b1) begin
            failures++;
            $display("[TB] FAIL nb_mem_stall got=%b exp=%b", rfIf.ds_stall, 1'b1);
        end
        step();
        driveMs(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        driveWb(1'b1, 1'b1, 5'd4, 32'h0000_4444);
        #1;
        checks++;
        if (rfIf.ds_stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL nb_wb_clear got=%b exp=%b", rfIf.ds_stall, 1'b0);
        end
        checks++;
        if (rfIf.rdata2 !== 32'h0000_4444) begin
            failures++;
            $display("[TB] FAIL nb_wb_value got=%h exp=%h", rfIf.rdata2, 32'h0000_4444);
        end
        step();
        driveWb(1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        checks++;
        if (rfIf.rdata2 !== 32'h0000_4444) begin
            failures++;
            $display("[TB] FAIL nb_array_value got=%h exp=%h", rfIf.rdata2, 32'h0000_4444);
        end
        // port 1 hazard, with the producer sitting in MEM as an outstanding load
        driveRead(5'd8, 1'b1, 5'd0, 1'b0);
        driveMs(1'b1, 1'b1, 1'b0, 5'd8, 32'h0);
        #1;
        checks++;
        if (rfIf.ds_stall !== 1'b1) begin
            failures++;
            $display("[TB] FAIL nb_port1_mem_stall got=%b exp=%b", rfIf.ds_stall, 1'b1);
        end
        driveMs(1'b1, 1'b1, 1'b1, 5'd9, 32'h0);
        #1;
        checks++;
        if (rfIf.ds_stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL nb_other_dest got=%b exp=%b", rfIf.ds_stall, 1'b0);
        end
        idle();
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        clk      = 1'b0;
        rst      = 1'b1;
        idle();
        driveRead(5'd5, 1'b1, 5'd0, 1'b0);
        #2;
        checks++;
        if (rfIf.rdata1 !== 32'h0) begin
            failures++;
            $display("[TB] FAIL initial_reset_read got=%h exp=%h", rfIf.rdata1, 32'h0);
        end
        #10 rst = 1'b0;
        step();

        test_reset();
        test_r0();
        test_write_through();
        test_same_addr();
        test_stall_gating();
`ifdef RF_BYPASS_EN
        test_priority();
        test_load_use();
`else
        test_no_bypass();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
